// File: rtl/q15_pkg.sv
// Shared Q15 (48.15 signed fixed-point) constants, operand class record,
// FSM state codes and the saturate/encode helper for the multiplier.
package q15_pkg;

  localparam int          Q15_FRAC_BITS  = 15;
  localparam logic [63:0] Q15_NAN        = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Q15_POS_INF    = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q15_NEG_INF    = 64'h8000_0000_0000_0001;
  localparam logic [63:0] Q15_MAX_FINITE = 64'h7FFF_FFFF_FFFF_FFFE;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand classification; mag is only meaningful for finite values
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        zero;
    logic        inf;
    logic [62:0] mag;
  } q15_class_t;

  // Turn an already-truncated product magnitude into a Q15 word.
  // Anything at or above 2^63-1 would collide with the inf/NaN codes,
  // so it saturates to inf; a zero magnitude never becomes -0.
  function automatic logic [63:0] q15_encode(input logic [110:0] mag,
                                             input logic        neg);
    logic [63:0] m64;
    m64 = {1'b0, mag[62:0]};
    if (mag > 111'(Q15_MAX_FINITE))
      return neg ? Q15_NEG_INF : Q15_POS_INF;
    else if (mag == '0)
      return 64'd0;
    else
      return neg ? -m64 : m64;
  endfunction

endpackage

// File: rtl/q15_classify.sv
// Combinational Q15 operand classifier: sign, NaN, zero, inf and the
// 63-bit magnitude of a finite value. Shared with the divider.
module q15_classify
  import q15_pkg::*;
(
  input  logic [63:0] data_i,
  output q15_class_t  cls_o
);

  logic [63:0] neg_w;

  assign neg_w      = -data_i;
  assign cls_o.sign = data_i[63];
  assign cls_o.nan  = (data_i == Q15_NAN);
  assign cls_o.inf  = (data_i == Q15_POS_INF) || (data_i == Q15_NEG_INF);
  assign cls_o.zero = (data_i == 64'd0);
  // Most negative finite is 0x8000..02, so |x| always fits in 63 bits
  assign cls_o.mag  = data_i[63] ? neg_w[62:0] : data_i[62:0];

endmodule

// File: rtl/q15_multiplier.sv
// Iterative signed Q15 multiplier. Specials are resolved in one cycle;
// finite operands run a shift-add over BITS_PER_CYCLE multiplier bits per
// cycle, then the product is truncated, saturated and re-encoded.
module q15_multiplier
  import q15_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1   // 1, 2, 4 or 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        launch_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nan_o,
  output logic [63:0] res_o
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = 64 / BITS_PER_CYCLE;

  q15_class_t ca, cb;

  logic [1:0]   state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [125:0] a_sh_q, a_sh_d;   // |a| pre-shifted to the current iteration offset
  logic [63:0]  b_sh_q, b_sh_d;   // |b| with consumed bits shifted out
  logic [125:0] acc_q, acc_d;
  logic         sign_q, sign_d;
  logic [63:0]  res_q, res_d;
  logic         nan_q, nan_d;

  logic [125:0] pp;
  logic [125:0] acc_sum;

  q15_classify u_cls_a (.data_i(a_i), .cls_o(ca));
  q15_classify u_cls_b (.data_i(b_i), .cls_o(cb));

  // Partial product of |a| (at offset) and the low BPC bits of |b|
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++)
      if (b_sh_q[i]) pp = pp + (a_sh_q << i);
  end

  assign acc_sum = acc_q + pp;

  // Next-state: special fast path, iteration, and final encode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    res_d   = res_q;
    nan_d   = nan_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_i) begin
          if (ca.nan || cb.nan || (ca.zero && cb.inf) || (ca.inf && cb.zero)) begin
            res_d   = Q15_NAN;
            nan_d   = 1'b1;
            state_d = ST_DONE;
          end else if (ca.inf || cb.inf) begin
            res_d   = (ca.sign ^ cb.sign) ? Q15_NEG_INF : Q15_POS_INF;
            nan_d   = 1'b0;
            state_d = ST_DONE;
          end else if (ca.zero || cb.zero) begin
            res_d   = 64'd0;
            nan_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            a_sh_d  = {63'd0, ca.mag};
            b_sh_d  = {1'b0, cb.mag};
            acc_d   = '0;
            cnt_d   = '0;
            sign_d  = ca.sign ^ cb.sign;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << BPC;
        b_sh_d = b_sh_q >> BPC;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'(N - 1)) begin
          // Result is registered here so it is valid during DONE
          res_d   = q15_encode(acc_sum[125:Q15_FRAC_BITS], sign_q);
          nan_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      nan_q   <= nan_d;
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign res_o  = res_q;
  assign nan_o  = nan_q;

endmodule

// File: tb/tb_q15_multiplier.sv
// Bench for q15_multiplier: two instances (1 and 4 bits per cycle) share
// stimulus; an arithmetic reference model predicts results and timing,
// and every cycle the outputs of both are compared against it.
module tb_q15_multiplier;

  localparam logic [63:0] NAN    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] POSINF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEGINF = 64'h8000_0000_0000_0001;
  localparam int          N1     = 64;
  localparam int          N4     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        launch = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  busy_w, done_w, nan_w;
  logic [63:0] res_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q15_multiplier #(.BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .launch_i(launch), .a_i(a), .b_i(b),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .nan_o(nan_w[0]), .res_o(res_w[0]));

  q15_multiplier #(.BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .launch_i(launch), .a_i(a), .b_i(b),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .nan_o(nan_w[1]), .res_o(res_w[1]));

  // ---------------- reference model ----------------
  function automatic logic is_inf(input logic [63:0] x);
    return (x == POSINF) || (x == NEGINF);
  endfunction

  function automatic logic is_fast(input logic [63:0] x, input logic [63:0] y);
    return x == 0 || y == 0 || x == NAN || y == NAN || is_inf(x) || is_inf(y);
  endfunction

  function automatic logic model_nan(input logic [63:0] x, input logic [63:0] y);
    return x == NAN || y == NAN || (is_inf(x) && y == 0) || (x == 0 && is_inf(y));
  endfunction

  function automatic logic [63:0] model_res(input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] px, py, p;
    logic [127:0] mag;
    if (model_nan(x, y)) return NAN;
    if (is_inf(x) || is_inf(y)) return (x[63] ^ y[63]) ? NEGINF : POSINF;
    if (x == 0 || y == 0) return 64'd0;
    px  = $signed(x);
    py  = $signed(y);
    p   = px * py;
    mag = (p < 0) ? 128'(-p) : 128'(p);
    mag = mag >> 15;
    if (mag >= 128'h7FFF_FFFF_FFFF_FFFF) return (p < 0) ? NEGINF : POSINF;
    if (mag == 0) return 64'd0;
    return (p < 0) ? 64'(128'd0 - mag) : mag[63:0];
  endfunction

  // Model timeline: done_iv is the edge after which done is high
  int          cyc = 0;
  int          done_iv [2] = '{-1000, -1000};
  logic        run_f   [2] = '{1'b0, 1'b0};
  logic [63:0] pend_r  [2] = '{64'd0, 64'd0};
  logic [63:0] prev_r  [2] = '{64'd0, 64'd0};
  logic        pend_n  [2] = '{1'b0, 1'b0};
  logic        prev_n  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        done_iv[d] <= -1000;
        run_f[d]   <= 1'b0;
        pend_r[d]  <= '0;
        prev_r[d]  <= '0;
        pend_n[d]  <= 1'b0;
        prev_n[d]  <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (launch && (cyc + 1 >= done_iv[d] + 2)) begin
          done_iv[d] <= cyc + 1 + (is_fast(a, b) ? 0 : ((d == 0) ? N1 : N4));
          run_f[d]   <= !is_fast(a, b);
          prev_r[d]  <= pend_r[d];
          prev_n[d]  <= pend_n[d];
          pend_r[d]  <= model_res(a, b);
          pend_n[d]  <= model_nan(a, b);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare both DUTs with the model
  task automatic tick();
    logic        eb, ed, en;
    logic [63:0] er;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      eb = run_f[d] && (cyc < done_iv[d]);
      ed = (cyc == done_iv[d]);
      er = (cyc >= done_iv[d]) ? pend_r[d] : prev_r[d];
      en = (cyc >= done_iv[d]) ? pend_n[d] : prev_n[d];
      check($sformatf("busy[%0d]", d), 64'(busy_w[d]), 64'(eb));
      check($sformatf("done[%0d]", d), 64'(done_w[d]), 64'(ed));
      check($sformatf("res[%0d]",  d), res_w[d], er);
      check($sformatf("nan[%0d]",  d), 64'(nan_w[d]), 64'(en));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if ((cyc + 1 >= done_iv[0] + 2) && (cyc + 1 >= done_iv[1] + 2)) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout t=%0t", $time);
  endtask

  // One launch pulse; checks latency of each DUT and the held result
  task automatic run_vec(input string nm, input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] er, input logic en, input int l1, input int l4);
    int k, s1, s4;
    wait_idle();
    a = va; b = vb; launch = 1'b1;
    k = cyc + 1; s1 = -1; s4 = -1;
    for (int i = 0; i < 80 && (s1 < 0 || s4 < 0); i++) begin
      tick();
      launch = 1'b0;
      if (done_w[0] && s1 < 0) s1 = cyc + 1 - k;
      if (done_w[1] && s4 < 0) s4 = cyc + 1 - k;
    end
    check({nm, " lat1"}, 64'(s1), 64'(l1));
    check({nm, " lat4"}, 64'(s4), 64'(l4));
    check({nm, " res1"}, res_w[0], er);
    check({nm, " res4"}, res_w[1], er);
    check({nm, " nan1"}, 64'(nan_w[0]), 64'(en));
    check({nm, " nan4"}, 64'(nan_w[1]), 64'(en));
  endtask

  initial begin
    int k, nd, s;
    // pin the model against hand-computed values
    check("pin 1.5*2.0",  model_res(64'hC000, 64'h10000), 64'h18000);
    check("pin -1*0.5",   model_res(64'hFFFF_FFFF_FFFF_8000, 64'h4000), 64'hFFFF_FFFF_FFFF_C000);
    check("pin trunc",    model_res(64'hFFFF_FFFF_FFFF_FFFF, 64'h4000), 64'd0);
    check("pin sat",      model_res(64'h7FFF_FFFF_FFFF_FFFE, 64'h10000), POSINF);
    check("pin 3*3",      model_res(64'h18000, 64'h18000), 64'h48000);
    check("pin inf*-2",   model_res(POSINF, 64'hFFFF_FFFF_FFFF_0000), NEGINF);
    check("pin 0*inf",    64'(model_nan(64'd0, POSINF)), 64'd1);

    repeat (3) tick();
    check("reset busy", 64'(busy_w), 64'd0);
    check("reset done", 64'(done_w), 64'd0);
    check("reset res",  res_w[0] | res_w[1], 64'd0);
    rst_n = 1'b1;
    tick();

    run_vec("1.5*2",     64'hC000, 64'h10000, 64'h18000, 1'b0, 65, 17);
    run_vec("-1*0.5",    64'hFFFF_FFFF_FFFF_8000, 64'h4000, 64'hFFFF_FFFF_FFFF_C000, 1'b0, 65, 17);
    run_vec("tiny*0.5",  64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 64'd0, 1'b0, 65, 17);
    run_vec("sat+",      64'h7FFF_FFFF_FFFF_FFFE, 64'h10000, POSINF, 1'b0, 65, 17);
    run_vec("sat-",      64'h8000_0000_0000_0002, 64'h10000, NEGINF, 1'b0, 65, 17);
    run_vec("max*1",     64'h7FFF_FFFF_FFFF_FFFE, 64'h8000, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 65, 17);
    run_vec("-max*1",    64'h8000_0000_0000_0002, 64'h8000, 64'h8000_0000_0000_0002, 1'b0, 65, 17);
    run_vec("-1.5*-2",   64'hFFFF_FFFF_FFFF_4000, 64'hFFFF_FFFF_FFFF_0000, 64'h18000, 1'b0, 65, 17);
    run_vec("lsb*1",     64'h1, 64'h8000, 64'h1, 1'b0, 65, 17);
    run_vec("nan*1",     NAN, 64'h8000, NAN, 1'b1, 1, 1);
    run_vec("0*inf",     64'd0, POSINF, NAN, 1'b1, 1, 1);
    run_vec("inf*-2",    POSINF, 64'hFFFF_FFFF_FFFF_0000, NEGINF, 1'b0, 1, 1);
    run_vec("0*5",       64'd0, 64'h28000, 64'd0, 1'b0, 1, 1);

    // launch held high, operands toggled during RUN
    wait_idle();
    a = 64'hC000; b = 64'h10000; launch = 1'b1;
    k = cyc + 1; nd = 0;
    for (int i = 0; i <= N1 + 1; i++) begin
      tick();
      if (done_w[0]) nd++;
      if (i < N1) begin
        a = 64'h1234_0000 + 64'(i);
        b = 64'h5555 ^ 64'(i);
      end
      if (i == N1) begin
        check("held res", res_w[0], 64'h18000);
        a = 64'h18000; b = 64'h18000;
      end
    end
    check("held one result", 64'(nd), 64'd1);
    tick();
    launch = 1'b0;
    s = -1;
    for (int i = 0; i < 80 && s < 0; i++) begin
      tick();
      if (done_w[0]) s = cyc - k;
    end
    check("b2b done edge", 64'(s), 64'(2 * N1 + 2));
    check("b2b res", res_w[0], 64'h48000);

    // reset in the middle of RUN
    wait_idle();
    a = 64'hC000; b = 64'h10000; launch = 1'b1;
    tick();
    launch = 1'b0;
    repeat (29) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy_w[0]), 64'd0);
    check("abort done", 64'(done_w[0]), 64'd0);
    check("abort res",  res_w[0], 64'd0);
    check("abort nan",  64'(nan_w[0]), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    run_vec("3*3", 64'h18000, 64'h18000, 64'h48000, 1'b0, 65, 17);
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
